ls_cfg_sequencer: RTL and testbench
===================================

LS_CFG_SEQUENCER -- requirements
Module: ls_cfg_sequencer

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 4: AXI4-Lite address width; the register window is offsets 0x0-0xC.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32: AXI4-Lite data width; fixed at 32.
REQ-003 Parameter C_TIMEOUT, default 255: maximum number of cycles to wait in any handshake state.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that launches a sequence.
REQ-008 cfg_data  in  128  four words; word k is bits [32k+31:32k].
REQ-009 busy  out  1  high while a sequence is running.
REQ-010 done  out  1  one-cycle pulse at the end of every sequence, pass or fail.
REQ-011 error  out  1  sequence failed; held until the next accepted start.
REQ-012 err_code  out  2  0=none, 1=bad response, 2=readback mismatch, 3=timeout.
REQ-013 rd_data  out  128  captured readback words, same packing as cfg_data.
REQ-014 M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY: AXI4-Lite master write channels.
REQ-015 M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: AXI4-Lite master read channels.

Function
REQ-016 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH.
REQ-017 IDLE: start latches cfg_data, clears error/err_code/rd_data, sets word index k=0, goes to WR_REQ; start is ignored in all other states.
REQ-018 WR_REQ: AWVALID and WVALID rise together with AWADDR=4k, WDATA=word k, WSTRB=4'hF, AWPROT=0.
REQ-019 AWVALID and WVALID each drop the cycle after its own READY is sampled high; go to WR_RESP once both handshakes complete, in either order or in the same cycle.
REQ-020 WR_RESP: BREADY=1. On BVALID with BRESP!=OKAY, err_code=1, go to FINISH. Otherwise k=k+1; after k=3, reset k=0 and go to RD_REQ, else go to WR_REQ.
REQ-021 RD_REQ: ARVALID=1, ARADDR=4k, ARPROT=0 until ARREADY, then go to RD_RESP.
REQ-022 RD_RESP: RREADY=1; on RVALID, capture RDATA into rd_data word k.
REQ-023 RD_RESP result checks, in priority order: RRESP!=OKAY sets err_code=1; else RDATA != latched word k sets err_code=2. Either error goes to FINISH, even if k<3.
REQ-024 RD_RESP with no error: after k=3 go to FINISH, else k=k+1 and go to RD_REQ.
REQ-025 Timeout: a 16-bit counter clears on every state entry and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP. On reaching C_TIMEOUT: drop all VALIDs, err_code=3, go to FINISH.
REQ-026 FINISH: done=1 for one cycle; error=(err_code!=0); go to IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 A VALID, once asserted, holds its address and data stable until its handshake or a timeout.
REQ-029 Minimum sequence length with zero-wait slaves: 2 cycles per write, 2 cycles per read, plus 1 cycle of FINISH.

Reset
REQ-030 ARESETN low immediately forces IDLE.
REQ-031 ARESETN low immediately drives all VALID/READY outputs, busy, done, error and err_code to 0, and rd_data, k and the timeout counter to 0.
REQ-032 A reset during a transaction drops VALIDs with no completion; no done pulse is produced.

Structure
REQ-033 Package ls_cfg_pkg holds the state enum, the err_code constants, the OKAY response encoding and the register offset constants.
REQ-034 The timeout counter is one sub-module, ls_timeout_cnt, with inputs clr and en, output expired, parameter LIMIT.

Verification
REQ-035 Zero-wait AXI4-Lite register slave, cfg=1,2,3,4 -> four writes to 0x0-0xC, rd_data=4,3,2,1 packed, done pulse, error=0, 17 cycles from start to done.
REQ-036 AWREADY delayed 3 cycles while WREADY is immediate -> WVALID drops first, AWVALID holds; no duplicate write occurs.
REQ-037 Slave returns BRESP=SLVERR on the second write -> no reads are issued, err_code=1, done pulse.
REQ-038 Slave corrupts the readback of offset 0x8 -> err_code=2, rd_data word 2 shows the corrupted value, no read of 0xC.
REQ-039 ARREADY held low, C_TIMEOUT=8 -> ARVALID drops after 8 cycles, err_code=3, done pulse.
REQ-040 ARESETN low during WR_RESP, then a new start -> outputs clear immediately and the new sequence completes normally; a start pulsed while busy is ignored.

Source files
------------

// File: rtl/ls_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite configuration sequencer.
package ls_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_FINISH
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_RESP     = 2'd1;
   localparam logic [1:0] ERR_MISMATCH = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam logic [3:0] OFS_WORD0 = 4'h0;
   localparam logic [3:0] OFS_WORD1 = 4'h4;
   localparam logic [3:0] OFS_WORD2 = 4'h8;
   localparam logic [3:0] OFS_WORD3 = 4'hC;

   localparam logic [1:0] LAST_WORD = 2'd3;

   function automatic logic [3:0] word_ofs(input logic [1:0] k);
      case (k)
         2'd0:    return OFS_WORD0;
         2'd1:    return OFS_WORD1;
         2'd2:    return OFS_WORD2;
         default: return OFS_WORD3;
      endcase
   endfunction

endpackage

// File: rtl/ls_cfg_sequencer_timeout.sv
// Per-state cycle counter; expired fires in the cycle whose increment would reach LIMIT.
module ls_timeout_cnt #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic [15:0] cnt_cur;

   // clr marks the first cycle of a state, so that cycle already counts from zero
   always_comb begin
      cnt_cur = clr ? 16'd0 : cnt_q;
      cnt_d   = en ? cnt_cur + 16'd1 : cnt_cur;
   end

   assign expired = en && (cnt_cur == 16'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ls_cfg_sequencer.sv
// Writes four configuration words over AXI4-Lite, reads them back and verifies them.
module ls_cfg_sequencer
   import ls_cfg_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_TIMEOUT          = 255
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic                            start,
   input  logic [127:0]                    cfg_data,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [1:0]                      err_code,
   output logic [127:0]                    rd_data,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   state_e          state_q;
   logic [1:0]      k_q;
   logic [3:0][31:0] cfg_q;
   logic [3:0][31:0] rd_q;
   logic [1:0]      err_code_q;
   logic            error_q;
   logic            done_q;
   logic            awvalid_q;
   logic            wvalid_q;
   logic            aw_done_q;
   logic            w_done_q;
   logic            bready_q;
   logic            arvalid_q;
   logic            rready_q;
   logic            entry_q;

   logic            tmo_en;
   logic            tmo;
   logic            aw_fire;
   logic            w_fire;
   logic            aw_ok;
   logic            w_ok;

   assign tmo_en  = state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP};
   assign aw_fire = awvalid_q && M_AXI_AWREADY;
   assign w_fire  = wvalid_q && M_AXI_WREADY;
   assign aw_ok   = aw_done_q || aw_fire;
   assign w_ok    = w_done_q || w_fire;

   ls_timeout_cnt #(
      .LIMIT (C_TIMEOUT)
   ) u_timeout (
      .clk     (ACLK),
      .rst_n   (ARESETN),
      .clr     (entry_q),
      .en      (tmo_en),
      .expired (tmo)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         cfg_q      <= '0;
         rd_q       <= '0;
         err_code_q <= ERR_NONE;
         error_q    <= 1'b0;
         done_q     <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         entry_q    <= 1'b0;
      end else begin
         entry_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cfg_q      <= cfg_data;
                  rd_q       <= '0;
                  err_code_q <= ERR_NONE;
                  error_q    <= 1'b0;
                  k_q        <= '0;
                  awvalid_q  <= 1'b1;
                  wvalid_q   <= 1'b1;
                  aw_done_q  <= 1'b0;
                  w_done_q   <= 1'b0;
                  entry_q    <= 1'b1;
                  state_q    <= ST_WR_REQ;
               end
            end
            ST_WR_REQ: begin
               // AW and W complete independently; each VALID drops on its own handshake
               if (aw_fire) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_fire) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if (aw_ok && w_ok) begin
                  bready_q <= 1'b1;
                  entry_q  <= 1'b1;
                  state_q  <= ST_WR_RESP;
               end else if (tmo) begin
                  awvalid_q  <= 1'b0;
                  wvalid_q   <= 1'b0;
                  err_code_q <= ERR_TIMEOUT;
                  error_q    <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= ST_FINISH;
               end
            end
            ST_WR_RESP: begin
               if (M_AXI_BVALID) begin
                  bready_q <= 1'b0;
                  if (M_AXI_BRESP != RESP_OKAY) begin
                     err_code_q <= ERR_RESP;
                     error_q    <= 1'b1;
                     done_q     <= 1'b1;
                     state_q    <= ST_FINISH;
                  end else if (k_q == LAST_WORD) begin
                     k_q       <= '0;
                     arvalid_q <= 1'b1;
                     entry_q   <= 1'b1;
                     state_q   <= ST_RD_REQ;
                  end else begin
                     k_q       <= k_q + 2'd1;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                     entry_q   <= 1'b1;
                     state_q   <= ST_WR_REQ;
                  end
               end else if (tmo) begin
                  bready_q   <= 1'b0;
                  err_code_q <= ERR_TIMEOUT;
                  error_q    <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= ST_FINISH;
               end
            end
            ST_RD_REQ: begin
               if (arvalid_q && M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  entry_q   <= 1'b1;
                  state_q   <= ST_RD_RESP;
               end else if (tmo) begin
                  arvalid_q  <= 1'b0;
                  err_code_q <= ERR_TIMEOUT;
                  error_q    <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= ST_FINISH;
               end
            end
            ST_RD_RESP: begin
               if (M_AXI_RVALID) begin
                  rready_q  <= 1'b0;
                  rd_q[k_q] <= M_AXI_RDATA;
                  // a bad response outranks a data mismatch
                  if (M_AXI_RRESP != RESP_OKAY) begin
                     err_code_q <= ERR_RESP;
                     error_q    <= 1'b1;
                     done_q     <= 1'b1;
                     state_q    <= ST_FINISH;
                  end else if (M_AXI_RDATA != cfg_q[k_q]) begin
                     err_code_q <= ERR_MISMATCH;
                     error_q    <= 1'b1;
                     done_q     <= 1'b1;
                     state_q    <= ST_FINISH;
                  end else if (k_q == LAST_WORD) begin
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     k_q       <= k_q + 2'd1;
                     arvalid_q <= 1'b1;
                     entry_q   <= 1'b1;
                     state_q   <= ST_RD_REQ;
                  end
               end else if (tmo) begin
                  rready_q   <= 1'b0;
                  err_code_q <= ERR_TIMEOUT;
                  error_q    <= 1'b1;
                  done_q     <= 1'b1;
                  state_q    <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               k_q     <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign rd_data       = rd_q;
   assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(word_ofs(k_q));
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = cfg_q[k_q];
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(word_ofs(k_q));
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_ls_cfg_sequencer.sv
// Directed bench: behavioural AXI4-Lite register slave with wait/error/corruption knobs.
module tb_ls_cfg_sequencer;

   logic         ACLK = 1'b0;
   logic         ARESETN;
   logic         start;
   logic [127:0] cfg_data;
   logic         busy, done, error;
   logic [1:0]   err_code;
   logic [127:0] rd_data;
   logic [3:0]   M_AXI_AWADDR;
   logic [2:0]   M_AXI_AWPROT;
   logic         M_AXI_AWVALID, M_AXI_AWREADY;
   logic [31:0]  M_AXI_WDATA;
   logic [3:0]   M_AXI_WSTRB;
   logic         M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]   M_AXI_BRESP;
   logic         M_AXI_BVALID, M_AXI_BREADY;
   logic [3:0]   M_AXI_ARADDR;
   logic [2:0]   M_AXI_ARPROT;
   logic         M_AXI_ARVALID, M_AXI_ARREADY;
   logic [31:0]  M_AXI_RDATA;
   logic [1:0]   M_AXI_RRESP;
   logic         M_AXI_RVALID, M_AXI_RREADY;

   always #5 ACLK = ~ACLK;

   ls_cfg_sequencer #(
      .C_M_AXI_ADDR_WIDTH (4),
      .C_M_AXI_DATA_WIDTH (32),
      .C_TIMEOUT          (8)
   ) dut (
      .ACLK (ACLK), .ARESETN (ARESETN), .start (start), .cfg_data (cfg_data),
      .busy (busy), .done (done), .error (error), .err_code (err_code), .rd_data (rd_data),
      .M_AXI_AWADDR (M_AXI_AWADDR), .M_AXI_AWPROT (M_AXI_AWPROT),
      .M_AXI_AWVALID (M_AXI_AWVALID), .M_AXI_AWREADY (M_AXI_AWREADY),
      .M_AXI_WDATA (M_AXI_WDATA), .M_AXI_WSTRB (M_AXI_WSTRB),
      .M_AXI_WVALID (M_AXI_WVALID), .M_AXI_WREADY (M_AXI_WREADY),
      .M_AXI_BRESP (M_AXI_BRESP), .M_AXI_BVALID (M_AXI_BVALID), .M_AXI_BREADY (M_AXI_BREADY),
      .M_AXI_ARADDR (M_AXI_ARADDR), .M_AXI_ARPROT (M_AXI_ARPROT),
      .M_AXI_ARVALID (M_AXI_ARVALID), .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RDATA (M_AXI_RDATA), .M_AXI_RRESP (M_AXI_RRESP),
      .M_AXI_RVALID (M_AXI_RVALID), .M_AXI_RREADY (M_AXI_RREADY)
   );

   // slave knobs, driven by the stimulus process
   int         aw_delay    = 0;
   bit         ar_ready_en = 1'b1;
   int         err_wr_idx  = -1;
   bit         corrupt_en  = 1'b0;
   logic [3:0] corrupt_addr = 4'h0;
   bit         tb_clr      = 1'b0;

   // slave state and statistics
   logic [31:0] mem [4];
   int          aw_wait;
   logic        aw_have, w_have, bvalid, rvalid;
   logic [3:0]  aw_addr_l;
   logic [31:0] w_data_l, rdata;
   logic [1:0]  bresp;
   int          wr_cnt, aw_hs, w_hs, rd_cnt, arv_cycles, done_cnt;
   bit [3:0]    rd_mask;
   bit          aw_alone, strb_bad, prot_bad;

   logic        aw_fire, w_fire, ar_fire, aw_have_n, w_have_n, wr_commit;
   logic [3:0]  aw_addr_n;
   logic [31:0] w_data_n;

   assign M_AXI_AWREADY = (aw_wait >= aw_delay);
   assign M_AXI_WREADY  = 1'b1;
   assign M_AXI_ARREADY = ar_ready_en;
   assign M_AXI_BVALID  = bvalid;
   assign M_AXI_BRESP   = bresp;
   assign M_AXI_RVALID  = rvalid;
   assign M_AXI_RDATA   = rdata;
   assign M_AXI_RRESP   = 2'b00;

   assign aw_fire   = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_fire    = M_AXI_WVALID && M_AXI_WREADY;
   assign ar_fire   = M_AXI_ARVALID && M_AXI_ARREADY;
   assign aw_have_n = aw_have || aw_fire;
   assign w_have_n  = w_have || w_fire;
   assign aw_addr_n = aw_fire ? M_AXI_AWADDR : aw_addr_l;
   assign w_data_n  = w_fire ? M_AXI_WDATA : w_data_l;
   assign wr_commit = aw_have_n && w_have_n && !bvalid;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_wait <= 0;
         aw_have <= 1'b0;
         w_have  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= 2'b00;
         rvalid  <= 1'b0;
         rdata   <= 32'h0;
      end else begin
         if (aw_fire) aw_wait <= 0;
         else if (M_AXI_AWVALID) aw_wait <= aw_wait + 1;
         if (wr_commit) begin
            mem[aw_addr_n[3:2]] <= w_data_n;
            bvalid  <= 1'b1;
            bresp   <= (wr_cnt == err_wr_idx) ? 2'b10 : 2'b00;
            aw_have <= 1'b0;
            w_have  <= 1'b0;
         end else begin
            aw_have   <= aw_have_n;
            w_have    <= w_have_n;
            aw_addr_l <= aw_addr_n;
            w_data_l  <= w_data_n;
         end
         if (bvalid && M_AXI_BREADY) bvalid <= 1'b0;
         if (ar_fire) begin
            rvalid <= 1'b1;
            rdata  <= mem[M_AXI_ARADDR[3:2]] ^
                      ((corrupt_en && M_AXI_ARADDR == corrupt_addr) ? 32'hDEAD0000 : 32'h0);
         end else if (rvalid && M_AXI_RREADY) begin
            rvalid <= 1'b0;
         end
         if (tb_clr) begin
            wr_cnt <= 0; aw_hs <= 0; w_hs <= 0; rd_cnt <= 0; arv_cycles <= 0; done_cnt <= 0;
            rd_mask <= 4'b0; aw_alone <= 1'b0; strb_bad <= 1'b0; prot_bad <= 1'b0;
         end else begin
            if (wr_commit) wr_cnt <= wr_cnt + 1;
            if (aw_fire) aw_hs <= aw_hs + 1;
            if (w_fire) w_hs <= w_hs + 1;
            if (ar_fire) begin
               rd_cnt <= rd_cnt + 1;
               rd_mask[M_AXI_ARADDR[3:2]] <= 1'b1;
            end
            if (M_AXI_ARVALID) arv_cycles <= arv_cycles + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (M_AXI_AWVALID && !M_AXI_WVALID) aw_alone <= 1'b1;
            if (w_fire && M_AXI_WSTRB != 4'hF) strb_bad <= 1'b1;
            if ((aw_fire && M_AXI_AWPROT != 3'b0) || (ar_fire && M_AXI_ARPROT != 3'b0)) prot_bad <= 1'b1;
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      @(negedge ACLK);
      tb_clr = 1'b1;
      @(negedge ACLK);
      tb_clr = 1'b0;
   endtask

   // Pulses start and counts cycles until done; ghost_cyc>0 re-pulses start while busy.
   task automatic run_seq(input logic [127:0] c, input int ghost_cyc, output int cyc);
      @(negedge ACLK);
      cfg_data = c;
      start    = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 200) begin
         if (cyc == ghost_cyc) begin
            start    = 1'b1;
            cfg_data = ~c;
         end
         @(posedge ACLK); #1;
         start = 1'b0;
         cyc++;
      end
      check_val("done_seen", 128'(done), 128'(1));
      $display("seq cfg=%h cycles=%0d err_code=%0d error=%0d rd_data=%h",
               c, cyc, err_code, error, rd_data);
      @(posedge ACLK); #1;
      check_val("done_one_cycle", 128'({done, busy}), 128'(0));
   endtask

   localparam logic [127:0] CFG_A = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [127:0] CFG_B = {32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001};
   localparam logic [127:0] CFG_C = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   localparam logic [127:0] CFG_D = {32'd8, 32'd7, 32'd6, 32'd5};
   localparam logic [127:0] CFG_E = {32'hA5A5_0003, 32'h5A5A_0002, 32'h0F0F_0001, 32'hF0F0_0000};

   initial begin
      int cyc;
      start    = 1'b0;
      cfg_data = '0;
      ARESETN  = 1'b1;
      #2 ARESETN = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      check_val("rst_status", 128'({busy, done, error, err_code}), 128'(0));
      check_val("rst_axi", 128'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 128'(0));
      check_val("rst_rd_data", rd_data, 128'(0));
      @(negedge ACLK);
      ARESETN = 1'b1;

      // zero-wait slave, full pass
      clr_stats();
      run_seq(CFG_A, 0, cyc);
      check_val("t1_cycles", 128'(cyc), 128'(17));
      check_val("t1_err", 128'({error, err_code}), 128'(0));
      check_val("t1_rd_data", rd_data, {32'd4, 32'd3, 32'd2, 32'd1});
      check_val("t1_mem", {mem[3], mem[2], mem[1], mem[0]}, {32'd4, 32'd3, 32'd2, 32'd1});
      check_val("t1_xfers", 128'({wr_cnt[7:0], rd_cnt[7:0], 4'(rd_mask)}), 128'({8'd4, 8'd4, 4'hF}));
      check_val("t1_done_cnt", 128'(done_cnt), 128'(1));
      check_val("t1_aw_alone", 128'(aw_alone), 128'(0));
      check_val("t1_strb_prot", 128'({strb_bad, prot_bad}), 128'(0));

      // AWREADY late by 3 cycles, WREADY immediate
      aw_delay = 3;
      clr_stats();
      run_seq(CFG_B, 0, cyc);
      aw_delay = 0;
      check_val("t2_cycles", 128'(cyc), 128'(29));
      check_val("t2_err", 128'({error, err_code}), 128'(0));
      check_val("t2_rd_data", rd_data, CFG_B);
      check_val("t2_hs", 128'({aw_hs[7:0], w_hs[7:0], wr_cnt[7:0]}), 128'({8'd4, 8'd4, 8'd4}));
      check_val("t2_aw_alone", 128'(aw_alone), 128'(1));

      // SLVERR on second write
      err_wr_idx = 1;
      clr_stats();
      run_seq(CFG_A, 0, cyc);
      err_wr_idx = -1;
      check_val("t3_cycles", 128'(cyc), 128'(5));
      check_val("t3_err", 128'({error, err_code}), 128'({1'b1, 2'd1}));
      check_val("t3_counts", 128'({wr_cnt[7:0], rd_cnt[7:0]}), 128'({8'd2, 8'd0}));
      check_val("t3_rd_data", rd_data, 128'(0));

      // readback of 0x8 corrupted
      corrupt_en   = 1'b1;
      corrupt_addr = 4'h8;
      clr_stats();
      run_seq(CFG_C, 0, cyc);
      corrupt_en = 1'b0;
      check_val("t4_cycles", 128'(cyc), 128'(15));
      check_val("t4_err", 128'({error, err_code}), 128'({1'b1, 2'd2}));
      check_val("t4_rd_data", rd_data, {32'h0, 32'hED9E3333, 32'h22222222, 32'h11111111});
      check_val("t4_rd_mask", 128'(rd_mask), 128'(4'b0111));

      // ARREADY stuck low, timeout of 8
      ar_ready_en = 1'b0;
      clr_stats();
      run_seq(CFG_D, 0, cyc);
      check_val("t5_cycles", 128'(cyc), 128'(17));
      check_val("t5_err", 128'({error, err_code}), 128'({1'b1, 2'd3}));
      check_val("t5_arv_cycles", 128'(arv_cycles), 128'(8));
      check_val("t5_arvalid_low", 128'({M_AXI_ARVALID, rd_cnt[7:0]}), 128'(0));
      ar_ready_en = 1'b1;

      // reset in WR_RESP, then a clean sequence with a start pulsed while busy
      clr_stats();
      @(negedge ACLK);
      cfg_data = CFG_A;
      start    = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
      @(posedge ACLK); #1;
      check_val("t6_bready_pre", 128'(M_AXI_BREADY), 128'(1));
      ARESETN = 1'b0;
      #1;
      check_val("t6_rst_status", 128'({busy, done, error, err_code}), 128'(0));
      check_val("t6_rst_axi", 128'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 128'(0));
      @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);
      check_val("t6_no_done", 128'(done_cnt), 128'(0));
      clr_stats();
      run_seq(CFG_E, 5, cyc);
      check_val("t6_cycles", 128'(cyc), 128'(17));
      check_val("t6_err", 128'({error, err_code}), 128'(0));
      check_val("t6_rd_data", rd_data, CFG_E);
      repeat (3) @(posedge ACLK);
      #1;
      check_val("t6_ghost_ignored", 128'({busy, done_cnt[7:0]}), 128'({1'b0, 8'd1}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
